// File: rtl/spike_aer_encoder_if.sv
// AER output stream: head word plus valid/ready handshake.
interface spike_aer_encoder_if;
  logic [7:0] aer_data;
  logic       aer_valid;
  logic       aer_ready;

  modport master (output aer_data, output aer_valid, input aer_ready);
  modport slave  (input aer_data, input aer_valid, output aer_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Spike vector to serial AER encoder: pending mask, lowest-index arbiter,
// small FIFO, 5-bit timestamp, sticky overflow and saturating drop counter.
module spike_aer_encoder #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N-1:0]           spike_in,
  spike_aer_encoder_if.master    aer,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  pending;
  logic [4:0]    ts;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic [N-1:0]  grant, gmask, coll;
  logic [2:0]    gidx;
  logic [CW-1:0] ncoll;
  logic [8:0]    drop_sum;
  logic          pop, push;

  assign aer.aer_valid = (count != '0);
  assign aer.aer_data  = mem[rd_ptr];
  assign pop           = aer.aer_valid & aer.aer_ready;

  // Arbiter: lowest pending bit wins; a full FIFO accepts only alongside a pop.
  always_comb begin
    grant = pending & (~pending + N'(1));
    gidx  = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pending[i]) gidx = 3'(i);
    push  = ena & (pending != '0) & ((count < (AW+1)'(DEPTH)) | pop);
    gmask = push ? grant : '0;
    // A fresh spike on a still-pending, un-granted bit has nowhere to go.
    coll  = ena ? (spike_in & pending & ~gmask) : '0;
    ncoll = '0;
    for (int i = 0; i < N; i++)
      ncoll = ncoll + CW'(coll[i]);
    drop_sum = {1'b0, drop_cnt} + 9'(ncoll);
  end

  // Capture spikes into the pending mask and advance the timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ts      <= '0;
    end else if (ena) begin
      pending <= (pending & ~gmask) | spike_in;
      ts      <= ts + 5'd1;
    end
  end

  // FIFO storage and pointers; storage is cleared so the head is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {ts, gidx};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Congestion flags: sticky overflow and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (coll != '0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder; expected words are {ts, addr}.
module tb_spike_aer_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] spike_in;
  logic       overflow;
  logic [7:0] drop_cnt;
  int         n_cmp = 0;
  int         n_err = 0;

  spike_aer_encoder_if aer ();

  spike_aer_encoder #(.N(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spike_in (spike_in),
    .aer      (aer),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    ena           = 1'b0;
    spike_in      = '0;
    aer.aer_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Backpressure drain order: bit 0 refired while granted, so lowest-index
  // arbitration serves it again right away; the rest follow in address order.
  logic [7:0] bp_exp [9];

  initial begin
    bp_exp = '{8'h08, 8'h10, 8'h19, 8'h22, 8'h3B, 8'h4C, 8'h55, 8'h5E, 8'h67};

    // Reset state
    rst_n = 1'b0; ena = 1'b0; spike_in = '0; aer.aer_ready = 1'b0;
    #12;
    chk("rst_valid", {7'b0, aer.aer_valid}, 8'h00);
    chk("rst_data", aer.aer_data, 8'h00);
    chk("rst_ovf", {7'b0, overflow}, 8'h00);
    chk("rst_drop", drop_cnt, 8'h00);

    // Single spike on bit 2 at ts=0: pushed next edge as {1,2}
    do_reset();
    ena = 1'b1; aer.aer_ready = 1'b1; spike_in = 8'b0000_0100;
    tick(); spike_in = '0;
    chk("single_lat0", {7'b0, aer.aer_valid}, 8'h00);
    tick();
    chk("single_valid", {7'b0, aer.aer_valid}, 8'h01);
    chk("single_data", aer.aer_data, 8'h0A);
    tick();
    chk("single_gone", {7'b0, aer.aer_valid}, 8'h00);
    chk("single_drop", drop_cnt, 8'h00);

    // All neurons at once: addr k emitted with ts k+1
    do_reset();
    ena = 1'b1; aer.aer_ready = 1'b1; spike_in = 8'hFF;
    tick(); spike_in = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("all_valid", {7'b0, aer.aer_valid}, 8'h01);
      chk("all_data", aer.aer_data, {5'(k + 1), 3'(k)});
    end
    tick();
    chk("all_empty", {7'b0, aer.aer_valid}, 8'h00);
    chk("all_ovf", {7'b0, overflow}, 8'h00);
    chk("all_drop", drop_cnt, 8'h00);

    // Backpressure, drops, then a full-FIFO push/pop edge
    do_reset();
    ena = 1'b1; aer.aer_ready = 1'b0; spike_in = 8'hFF;
    tick(); tick();
    spike_in = '0;
    chk("bp_drop", drop_cnt, 8'd7);
    chk("bp_ovf", {7'b0, overflow}, 8'h01);
    repeat (5) tick();
    chk("bp_head0", aer.aer_data, bp_exp[0]);
    chk("bp_valid", {7'b0, aer.aer_valid}, 8'h01);
    aer.aer_ready = 1'b1;
    tick(); aer.aer_ready = 1'b0;
    chk("full_pp_head", aer.aer_data, bp_exp[1]);
    tick();
    chk("bp_hold", aer.aer_data, bp_exp[1]);
    aer.aer_ready = 1'b1;
    for (int i = 2; i < 9; i++) begin
      tick();
      chk("bp_valid_i", {7'b0, aer.aer_valid}, 8'h01);
      chk("bp_data_i", aer.aer_data, bp_exp[i]);
    end
    tick();
    chk("bp_empty", {7'b0, aer.aer_valid}, 8'h00);
    chk("bp_drop_end", drop_cnt, 8'd7);

    // ena gating: spikes ignored, ts frozen, queue still drains
    do_reset();
    ena = 1'b1; aer.aer_ready = 1'b0; spike_in = 8'h03;
    tick(); spike_in = '0;
    tick();
    ena = 1'b0; spike_in = 8'hFF;
    tick(); tick();
    chk("ena_head", aer.aer_data, 8'h08);
    aer.aer_ready = 1'b1;
    tick();
    chk("ena_drained", {7'b0, aer.aer_valid}, 8'h00);
    tick();
    chk("ena_no_push", {7'b0, aer.aer_valid}, 8'h00);
    chk("ena_drop", drop_cnt, 8'h00);
    ena = 1'b1; spike_in = '0;
    tick();
    chk("ena_ts_frozen", aer.aer_data, 8'h11);
    tick();
    chk("ena_done", {7'b0, aer.aer_valid}, 8'h00);

    // Saturating drop counter, then reset mid-stream
    do_reset();
    ena = 1'b1; aer.aer_ready = 1'b0; spike_in = 8'hFF;
    repeat (50) tick();
    chk("sat_drop", drop_cnt, 8'hFF);
    chk("sat_ovf", {7'b0, overflow}, 8'h01);
    chk("sat_valid", {7'b0, aer.aer_valid}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, aer.aer_valid}, 8'h00);
    chk("mid_rst_drop", drop_cnt, 8'h00);
    chk("mid_rst_ovf", {7'b0, overflow}, 8'h00);
    chk("mid_rst_data", aer.aer_data, 8'h00);
    spike_in = '0; ena = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    ena = 1'b1; aer.aer_ready = 1'b1; spike_in = 8'h20;
    tick(); spike_in = '0;
    chk("post_rst_lat", {7'b0, aer.aer_valid}, 8'h00);
    tick();
    chk("post_rst_data", aer.aer_data, 8'h0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
